// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared constants and state type for the SPI register slave
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
    localparam logic [6:0] ADDR_DUTY      = 7'd4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } spi_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop input synchroniser with rise/fall pulse outputs
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Shift the asynchronous pin through the chain; prev holds last synchronised level
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {SYNC_STAGES{IDLE_LEVEL}};
            prev  <= IDLE_LEVEL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign dout = chain[SYNC_STAGES-1];
    assign rise = dout & ~prev;
    assign fall = ~dout & prev;

endmodule

// File: rtl/spi_reg_peripheral.sv
// rtl/spi_reg_peripheral.sv - SPI mode-0 register slave; optional readback via SPI_READBACK_EN
module spi_reg_peripheral
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_i,
    input  logic       copi_i,
    input  logic       ncs_i,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe_o,
    output logic       cipo_o
);

    logic sclk_unused_level, sclk_rise, sclk_fall;
    logic ncs_s, ncs_rise, ncs_fall;
    logic copi_s, copi_unused_rise, copi_unused_fall;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk_i),
        .dout(sclk_unused_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .din(ncs_i),
        .dout(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .din(copi_i),
        .dout(copi_s), .rise(copi_unused_rise), .fall(copi_unused_fall)
    );

    spi_state_t            state;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [4:0]            bit_cnt;
    logic                  overflow;
    logic                  frame_ok;

    // A frame commits only if it is exactly 16 bits, a write, and addresses a real register
    assign frame_ok = (bit_cnt == 5'(FRAME_BITS)) && !overflow && shift_reg[15]
                      && (shift_reg[14:8] <= 7'(MAX_ADDR));

    // Frame FSM: shift on SCLK rise, decide on nCS rise, write registers in COMMIT only
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            shift_reg       <= '0;
            bit_cnt         <= '0;
            overflow        <= 1'b0;
            wr_strobe_o     <= 1'b0;
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else begin
            wr_strobe_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        state     <= SHIFT;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        overflow  <= 1'b0;
                    end
                end
                SHIFT: begin
                    // nCS rise wins over a coincident SCLK rise, which is dropped
                    if (ncs_rise) begin
                        state <= frame_ok ? COMMIT : IDLE;
                    end else if (sclk_rise && !ncs_s) begin
                        if (bit_cnt < 5'(FRAME_BITS)) begin
                            shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_s};
                            bit_cnt   <= bit_cnt + 5'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    wr_strobe_o <= 1'b1;
                    case (shift_reg[14:8])
                        ADDR_EN_OUT_LO: en_reg_out_7_0  <= shift_reg[7:0];
                        ADDR_EN_OUT_HI: en_reg_out_15_8 <= shift_reg[7:0];
                        ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= shift_reg[7:0];
                        ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= shift_reg[7:0];
                        ADDR_DUTY:      pwm_duty_cycle  <= shift_reg[7:0];
                        default: ;
                    endcase
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic [7:0] tx_shift;
    logic [7:0] rd_data;
    logic [6:0] rd_addr;
    logic       rd_frame;
    logic       cipo_q;

    // On the 8th SCLK rise the address is the 6 bits already shifted plus the live sample
    assign rd_addr  = {shift_reg[5:0], copi_s};
    assign rd_frame = ~shift_reg[6];

    // Register file read mux; unmapped addresses read as zero
    always_comb begin
        rd_data = 8'h00;
        if (rd_addr <= 7'(MAX_ADDR)) begin
            case (rd_addr)
                ADDR_EN_OUT_LO: rd_data = en_reg_out_7_0;
                ADDR_EN_OUT_HI: rd_data = en_reg_out_15_8;
                ADDR_EN_PWM_LO: rd_data = en_reg_pwm_7_0;
                ADDR_EN_PWM_HI: rd_data = en_reg_pwm_15_8;
                ADDR_DUTY:      rd_data = pwm_duty_cycle;
                default:        rd_data = 8'h00;
            endcase
        end
    end

    // Load TX after the address byte, then present one bit per SCLK fall for frame bits 8-15
    always_ff @(posedge clk) begin
        if (rst || ncs_s || state != SHIFT) begin
            tx_shift <= 8'h00;
            cipo_q   <= 1'b0;
        end else begin
            if (sclk_rise && !ncs_rise && bit_cnt == 5'd7) begin
                tx_shift <= rd_frame ? rd_data : 8'h00;
            end
            if (sclk_fall) begin
                if (bit_cnt >= 5'd8 && bit_cnt <= 5'd15) begin
                    cipo_q   <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end else begin
                    cipo_q <= 1'b0;
                end
            end
        end
    end

    assign cipo_o = cipo_q;
`else
    logic unused_sclk_fall;
    assign unused_sclk_fall = sclk_fall;
    assign cipo_o           = 1'b0;
`endif

endmodule
